// File: rtl/flash_ctrl_rd_engine_if.sv
// Signal bundle between the flash read engine and its arbiter, flash phy and rd_fifo.
// The slave modport is the engine side; master is everything that surrounds it.
interface flash_ctrl_rd_engine_if #(
  parameter int BusWidth  = 32,
  parameter int NumWordsW = 12
);
  logic                 op_start_i;
  logic [31:0]          op_addr_i;
  logic [NumWordsW-1:0] op_num_words_i;
  logic                 op_abort_i;
  logic                 op_done_o;
  logic                 op_err_o;
  logic [31:0]          err_addr_o;

  logic                 flash_req_o;
  logic [29:0]          flash_addr_o;
  logic                 flash_done_i;
  logic [BusWidth-1:0]  flash_rdata_i;
  logic                 flash_err_i;

  logic                 data_wvalid_o;
  logic [BusWidth-1:0]  data_wdata_o;
  logic                 data_wready_i;

  modport slave (
    input  op_start_i, op_addr_i, op_num_words_i, op_abort_i,
    output op_done_o, op_err_o, err_addr_o,
    output flash_req_o, flash_addr_o,
    input  flash_done_i, flash_rdata_i, flash_err_i,
    output data_wvalid_o, data_wdata_o,
    input  data_wready_i
  );

  modport master (
    output op_start_i, op_addr_i, op_num_words_i, op_abort_i,
    input  op_done_o, op_err_o, err_addr_o,
    input  flash_req_o, flash_addr_o,
    output flash_done_i, flash_rdata_i, flash_err_i,
    input  data_wvalid_o, data_wdata_o,
    output data_wready_i
  );
endinterface

// File: rtl/flash_ctrl_rd_engine.sv
// Flash read engine: issues one word read at a time to the phy and pushes each
// returned word into the rd_fifo, reporting completion and the first error address.
module flash_ctrl_rd_engine #(
  parameter int BusWidth  = 32,
  parameter int NumWordsW = 12
) (
  input logic                  clk_i,
  input logic                  rst_i,
  flash_ctrl_rd_engine_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StPush,
    StDone,
    StDrain
  } state_e;

  state_e               state_q, state_d;
  logic                 start_q;
  logic                 start_block_q;
  logic [29:0]          word_addr_q;
  logic [NumWordsW-1:0] count_q;
  logic                 err_q;
  logic [31:0]          err_addr_q;
  logic [BusWidth-1:0]  hold_q;

  logic                 accept;
  logic                 capture;
  logic                 advance;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^bus.op_addr_i[1:0];

  // A start still high when reset releases is blocked until it has been seen low.
  assign accept = (state_q == StIdle) && bus.op_start_i && !start_q && !start_block_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StRead;
      end
      StRead: begin
        if (bus.op_abort_i) begin
          state_d = bus.flash_done_i ? StIdle : StDrain;
        end else if (bus.flash_done_i) begin
          capture = 1'b1;
          state_d = StPush;
        end
      end
      StPush: begin
        if (bus.op_abort_i) begin
          state_d = StIdle;
        end else if (bus.data_wready_i) begin
          if (count_q == '0) begin
            state_d = StDone;
          end else begin
            advance = 1'b1;
            state_d = StRead;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      StDrain: begin
        if (bus.flash_done_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      start_q       <= 1'b0;
      start_block_q <= bus.op_start_i;
      word_addr_q   <= '0;
      count_q       <= '0;
      err_q         <= 1'b0;
      err_addr_q    <= '0;
      hold_q        <= '0;
    end else begin
      start_q <= bus.op_start_i;
      if (!bus.op_start_i) start_block_q <= 1'b0;

      if (accept) begin
        word_addr_q <= bus.op_addr_i[31:2];
        count_q     <= bus.op_num_words_i;
        err_q       <= 1'b0;
      end

      if (capture) begin
        hold_q <= bus.flash_err_i ? '1 : bus.flash_rdata_i;
        if (bus.flash_err_i && !err_q) begin
          err_q      <= 1'b1;
          err_addr_q <= {word_addr_q, 2'b00};
        end
      end

      if (advance) begin
        count_q     <= count_q - NumWordsW'(1);
        word_addr_q <= word_addr_q + 30'd1;
      end
    end
  end

  // Abort in StDone suppresses the completion pulse in the same cycle.
  assign bus.op_done_o     = (state_q == StDone) && !bus.op_abort_i;
  assign bus.op_err_o      = bus.op_done_o && err_q;
  assign bus.err_addr_o    = err_addr_q;
  assign bus.flash_req_o   = (state_q == StRead);
  assign bus.flash_addr_o  = word_addr_q;
  assign bus.data_wvalid_o = (state_q == StPush);
  assign bus.data_wdata_o  = hold_q;

endmodule
